// File: rtl/tm_psum_accum_buffer.sv
// tm_psum_accum_buffer: multi-pass TM-channel partial-sum accumulator with saturated per-pixel drain.
// Optional PSUM_RELU_EN: clamp negative accumulators to 0 on drain.
module tm_psum_accum_buffer #(
  parameter int TM            = 16,
  parameter int FEATURE_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = 8,
  parameter int CH_WIDTH      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  input  logic [7:0]                  cfg_group_count,
  input  logic [ADDR_WIDTH:0]         cfg_pixel_count,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH_WIDTH-1:0]         in_channel,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [FEATURE_WIDTH-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [TM*FEATURE_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err_cfg,
  output logic                        err_range
);
  localparam int CI = TM > 1 ? $clog2(TM) : 1;
  localparam int AI = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 << (FEATURE_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] grp_q, grp_d, group_cnt_q, group_cnt_d;
  logic [ADDR_WIDTH:0] pix_q, pix_d;
  logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic err_range_q, err_range_d, err_cfg_q, err_cfg_d;
  logic [ACC_WIDTH-1:0] acc_q [TM][DEPTH];
  logic [ACC_WIDTH-1:0] acc_rd, acc_ext, acc_wdata;
  logic cfg_ok, start, fire, in_range, pass_end, last_group, drain_last, drain_fire, acc_we;
  always_comb begin
    cfg_ok     = cfg_group_count != 8'd0 && cfg_pixel_count != '0 &&
                 cfg_pixel_count <= (ADDR_WIDTH+1)'(DEPTH);
    start      = state_q == IDLE && cfg_valid && cfg_ok;
    fire       = in_valid && in_ready;
    in_range   = 32'(in_channel) < TM && {1'b0, in_addr} < pix_q;
    pass_end   = in_channel == CH_WIDTH'(TM-1) && {1'b0, in_addr} == pix_q - 1'b1;
    last_group = group_cnt_q == grp_q - 8'd1;
    drain_last = {1'b0, drain_addr_q} == pix_q - 1'b1;
    drain_fire = out_valid && out_ready;
    acc_we     = fire && in_range;
    acc_rd     = acc_q[in_channel[CI-1:0]][in_addr[AI-1:0]];
    acc_ext    = ACC_WIDTH'($signed(in_data));
    acc_wdata  = group_cnt_q == 8'd0 ? acc_ext : acc_rd + acc_ext;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ACCUM : IDLE;
      ACCUM:   state_d = fire && pass_end && last_group ? DRAIN : ACCUM;
      DRAIN:   state_d = drain_fire && drain_last ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grp_d        = start ? cfg_group_count : grp_q;
    pix_d        = start ? cfg_pixel_count : pix_q;
    group_cnt_d  = start ? 8'd0 : fire && pass_end ? group_cnt_q + 8'd1 : group_cnt_q;
    drain_addr_d = state_q == ACCUM ? '0 : drain_fire ? drain_addr_q + 1'b1 : drain_addr_q;
    err_range_d  = start ? 1'b0 : fire && !in_range ? 1'b1 : err_range_q;
    err_cfg_d    = state_q == IDLE && cfg_valid && !cfg_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grp_q        <= '0;
      pix_q        <= '0;
      group_cnt_q  <= '0;
      drain_addr_q <= '0;
      err_range_q  <= 1'b0;
      err_cfg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grp_q        <= grp_d;
      pix_q        <= pix_d;
      group_cnt_q  <= group_cnt_d;
      drain_addr_q <= drain_addr_d;
      err_range_q  <= err_range_d;
      err_cfg_q    <= err_cfg_d;
    end
  end
  // Read-modify-write in one edge, so repeated beats to one location need no bubble.
  always_ff @(posedge clk)
    if (acc_we) acc_q[in_channel[CI-1:0]][in_addr[AI-1:0]] <= acc_wdata;
  always_comb begin
    in_ready  = state_q == ACCUM;
    out_valid = state_q == DRAIN;
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    out_addr  = drain_addr_q;
    err_cfg   = err_cfg_q;
    err_range = err_range_q;
  end
  for (genvar c = 0; c < TM; c++) begin : g_sat
    logic signed [ACC_WIDTH-1:0] v;
    assign v = acc_q[c][drain_addr_q[AI-1:0]];
`ifdef PSUM_RELU_EN
    assign out_data[c*FEATURE_WIDTH +: FEATURE_WIDTH] = !out_valid || v < 0 ? '0 :
      v > MAXV ? MAXV[FEATURE_WIDTH-1:0] : v[FEATURE_WIDTH-1:0];
`else
    assign out_data[c*FEATURE_WIDTH +: FEATURE_WIDTH] = !out_valid ? '0 :
      v > MAXV ? MAXV[FEATURE_WIDTH-1:0] : v < MINV ? MINV[FEATURE_WIDTH-1:0] : v[FEATURE_WIDTH-1:0];
`endif
  end
endmodule

// File: tb/tb_tm_psum_accum_buffer.sv
// tb_tm_psum_accum_buffer: scoreboard bench for tm_psum_accum_buffer (default parameters).
module tb_tm_psum_accum_buffer;
  logic clk = 0, rst = 1, cfg_valid = 0, in_valid = 0, out_ready = 0;
  logic [7:0] cfg_group_count = 0;
  logic [8:0] cfg_pixel_count = 0;
  logic [4:0] in_channel = 0;
  logic [7:0] in_addr = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid, busy, done, err_cfg, err_range;
  logic [7:0] out_addr;
  logic [255:0] out_data;
  int model [16][256];
  int tb_grp, tb_pc, n_assert, n_fail;
  logic [263:0] exp_q [$];

  tm_psum_accum_buffer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_group_count(cfg_group_count),
    .cfg_pixel_count(cfg_pixel_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_channel(in_channel), .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .busy(busy),
    .done(done), .err_cfg(err_cfg), .err_range(err_range));

  always #5 clk = ~clk;

  function automatic int wrap24(input int x);
    return (x <<< 8) >>> 8;
  endfunction

  function automatic logic [15:0] satf(input int v);
`ifdef PSUM_RELU_EN
    if (v < 0) return 16'h0000;
`endif
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic start_job(input int gc, input int pc);
    @(negedge clk);
    cfg_valid = 1; cfg_group_count = gc[7:0]; cfg_pixel_count = pc[8:0];
    @(negedge clk);
    cfg_valid = 0; tb_grp = 0; tb_pc = pc;
    n_assert++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: busy=%b in_ready=%b, required 1/1", busy, in_ready);
    end
    n_assert++;
    if (err_range !== 1'b0) begin
      n_fail++; $display("FAIL start_err_range_clear: got %b, required 0", err_range);
    end
  endtask

  task automatic beat(input int ch, input int addr, input int data);
    int t = 0;
    int sd;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL beat_ready: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1; in_channel = ch[4:0]; in_addr = addr[7:0]; in_data = data[15:0];
    sd = int'($signed(data[15:0]));
    if (ch < 16 && addr < tb_pc) model[ch][addr] = tb_grp == 0 ? wrap24(sd) : wrap24(model[ch][addr] + sd);
    if (ch == 15 && addr == tb_pc - 1) tb_grp++;
  endtask

  task automatic end_beats();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain(input int pc, input int stall_word);
    int got = 0, cyc = 0, st = 0;
    logic [255:0] w, snap_d;
    logic [7:0] snap_a, ea;
    logic [263:0] e;
    for (int a = 0; a < pc; a++) begin
      for (int c = 0; c < 16; c++) w[c*16 +: 16] = satf(model[c][a]);
      ea = a[7:0];
      exp_q.push_back({ea, w});
    end
    while (got < pc && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = !(got == stall_word && st < 5);
      if (out_valid !== 1'b1) continue;
      if (!out_ready) begin
        if (st > 0) begin
          n_assert++;
          if (out_data !== snap_d || out_addr !== snap_a) begin
            n_fail++; $display("FAIL stall_stable: addr %0d data %h, required addr %0d data %h", out_addr, out_data, snap_a, snap_d);
          end
        end
        snap_d = out_data; snap_a = out_addr; st++;
      end else begin
        e = exp_q.pop_front();
        n_assert++;
        if (out_addr !== e[263:256]) begin
          n_fail++; $display("FAIL drain_addr: got %0d, required %0d", out_addr, e[263:256]);
        end
        n_assert++;
        if (out_data !== e[255:0]) begin
          n_fail++; $display("FAIL drain_data: addr %0d got %h, required %h", out_addr, out_data, e[255:0]);
        end
        got++;
      end
    end
    n_assert++;
    if (got != pc) begin
      n_fail++; $display("FAIL drain_timeout: got %0d words, required %0d", got, pc);
      exp_q.delete();
    end
    @(negedge clk);
    out_ready = 0;
    n_assert++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse: out_valid=%b done=%b, required 0/1", out_valid, done);
    end
    @(negedge clk);
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_once: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic check_latency();
    n_assert++;
    if (out_valid !== 1'b1 || out_addr !== 8'd0) begin
      n_fail++; $display("FAIL drain_latency: out_valid=%b addr=%0d, required 1/0", out_valid, out_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({out_valid, in_ready, busy, done, err_cfg, err_range, out_addr} !== 14'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 0", {out_valid, in_ready, busy, done, err_cfg, err_range, out_addr});
    end
    n_assert++;
    if (out_data !== 256'd0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", out_data);
    end
    rst = 0;
  endtask

  task automatic test_single_pass();
    start_job(1, 4);
    for (int a = 0; a < 4; a++)
      for (int c = 0; c < 16; c++) beat(c, a, c * 4 + a);
    end_beats();
    check_latency();
    drain(4, -1);
  endtask

  task automatic test_multi_pass();
    start_job(3, 1);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 16; c++) beat(c, 0, c == 0 ? 100 : c * 7);
    end_beats();
    check_latency();
    n_assert++;
    if (out_data[15:0] !== 16'd300) begin
      n_fail++; $display("FAIL multi_pass_ch0: got %0d, required 300", out_data[15:0]);
    end
    drain(1, -1);
  endtask

  task automatic test_saturation();
    start_job(3, 1);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 16; c++) beat(c, 0, c == 0 ? 30000 : c == 1 ? -30000 : c == 2 ? -5 : c);
    end_beats();
    check_latency();
    n_assert++;
`ifdef PSUM_RELU_EN
    if (out_data[31:0] !== 32'h0000_7fff) begin
      n_fail++; $display("FAIL sat_pos_neg: got %h, required 00007fff", out_data[31:0]);
    end
`else
    if (out_data[31:0] !== 32'h8000_7fff) begin
      n_fail++; $display("FAIL sat_pos_neg: got %h, required 80007fff", out_data[31:0]);
    end
`endif
    drain(1, -1);
  endtask

  task automatic test_back_to_back();
    start_job(2, 1);
    beat(0, 0, 5); beat(0, 0, 9);
    for (int c = 1; c < 16; c++) beat(c, 0, c);
    beat(0, 0, 1); beat(0, 0, 2); beat(0, 0, 3);
    for (int c = 1; c < 16; c++) beat(c, 0, 1);
    end_beats();
    check_latency();
    n_assert++;
    if (out_data[15:0] !== 16'd15) begin
      n_fail++; $display("FAIL back_to_back_ch0: got %0d, required 15", out_data[15:0]);
    end
    drain(1, -1);
  endtask

  task automatic test_backpressure();
    logic [15:0] r;
    start_job(1, 8);
    for (int a = 0; a < 8; a++)
      for (int c = 0; c < 16; c++) begin
        r = 16'($urandom);
        beat(c, a, int'($signed(r)));
      end
    end_beats();
    check_latency();
    drain(8, 3);
  endtask

  task automatic test_errors();
    int bad [3][2] = '{'{1, 0}, '{1, 257}, '{0, 4}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_valid = 1; cfg_group_count = bad[i][0][7:0]; cfg_pixel_count = bad[i][1][8:0];
      @(negedge clk);
      cfg_valid = 0;
      n_assert++;
      if (err_cfg !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL err_cfg_pulse: case %0d err_cfg=%b busy=%b, required 1/0", i, err_cfg, busy);
      end
      @(negedge clk);
      n_assert++;
      if (err_cfg !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL err_cfg_single: case %0d err_cfg=%b busy=%b, required 0/0", i, err_cfg, busy);
      end
    end
    start_job(1, 3);
    for (int c = 0; c < 16; c++) beat(c, 0, 1000 + c);
    beat(0, 3, 77);
    beat(20, 0, 555);
    n_assert++;
    if (err_range !== 1'b1) begin
      n_fail++; $display("FAIL err_range_set: got %b, required 1", err_range);
    end
    for (int a = 1; a < 3; a++)
      for (int c = 0; c < 16; c++) beat(c, a, a * 100 - c);
    end_beats();
    check_latency();
    drain(3, -1);
    n_assert++;
    if (err_range !== 1'b1) begin
      n_fail++; $display("FAIL err_range_sticky: got %b, required 1", err_range);
    end
    start_job(1, 1);
    for (int c = 0; c < 16; c++) beat(c, 0, -c);
    end_beats();
    drain(1, -1);
  endtask

  task automatic test_reset_mid();
    start_job(1, 4);
    for (int i = 0; i < 10; i++) beat(i, 0, 50 + i);
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    n_assert++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b, required 0/0/0", busy, in_ready, out_valid);
    end
    start_job(1, 2);
    for (int a = 0; a < 2; a++)
      for (int c = 0; c < 16; c++) beat(c, a, 3 * c - a);
    end_beats();
    check_latency();
    drain(2, -1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tm_psum_accum_buffer.md
Name: tm_psum_accum_buffer

Overview:
- Multi-pass partial-sum accumulation buffer for TM output channels, placed after the scaling unit in the configurable data path.
- Accepts one scaled feature per cycle, tagged with its output channel and pixel address, and accumulates it across CFG group passes (one pass per Tn input-channel group).
- After the final pass, drains all TM channels per pixel as one saturated wide word through a valid/ready handshake.

Parameters:
- TM, 16, number of output channels held.
- FEATURE_WIDTH, 16, signed width of the input and output features.
- ACC_WIDTH, 24, signed accumulator width; must be >= FEATURE_WIDTH.
- DEPTH, 256, pixels per channel.
- ADDR_WIDTH, 8, pixel address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- CH_WIDTH, 5, channel index width; must satisfy 2**CH_WIDTH >= TM.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  start a job; sampled in IDLE only.
- cfg_group_count  in  8  number of accumulation passes.
- cfg_pixel_count  in  ADDR_WIDTH+1  pixels per channel.
- in_valid  in  1  input feature valid.
- in_ready  out  1  high only in ACCUM.
- in_channel  in  CH_WIDTH  output channel index.
- in_addr  in  ADDR_WIDTH  pixel address.
- in_data  in  FEATURE_WIDTH  signed scaled feature.
- out_valid  out  1  drain word valid.
- out_ready  in  1  downstream accept.
- out_addr  out  ADDR_WIDTH  pixel of the current drain word.
- out_data  out  TM*FEATURE_WIDTH  channel i in bits [(i+1)*FEATURE_WIDTH-1 : i*FEATURE_WIDTH].
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when the job completes.
- err_cfg  out  1  one-cycle pulse on an illegal configuration.
- err_range  out  1  sticky flag for a dropped input; cleared on the next accepted cfg_valid.

Behaviour:
- Reset state: FSM in IDLE. All outputs 0. Internal counters 0. Accumulator contents are don't-care.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE, cfg_valid=1 with legal config:
  - Legal config: group_count != 0, pixel_count != 0, pixel_count <= DEPTH.
  - Latch the config, clear err_range, group_cnt=0, go to ACCUM.
- IDLE, cfg_valid=1 with illegal config: err_cfg=1 for one cycle, stay in IDLE.
- ACCUM, input accepted (in_valid & in_ready):
  - In range (in_channel < TM and in_addr < pixel_count): if group_cnt==0, acc[ch][addr] <= sign-extended in_data (overwrite); otherwise acc[ch][addr] <= acc[ch][addr] + in_data.
  - The add wraps in ACC_WIDTH.
  - Read and write complete in the same edge, so back-to-back beats to the same location are legal with no bubble.
  - Out of range: the beat is dropped, no write, err_range <= 1.
- Pass end: an accepted beat with in_channel==TM-1 and in_addr==pixel_count-1 ends the pass, whether or not it was in range. group_cnt increments. If group_cnt==group_count-1, go to DRAIN with the drain address at 0.
- DRAIN, word presentation:
  - out_valid=1, out_addr=drain address.
  - Each channel of out_data = sat(acc[ch][addr]): clamp to [-2**(FEATURE_WIDTH-1), 2**(FEATURE_WIDTH-1)-1].
  - out_data and out_addr hold stable while out_valid & !out_ready.
- DRAIN, word accepted: advance the address. After the handshake at pixel_count-1, out_valid deasserts on the next cycle and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- cfg_valid is ignored outside IDLE.
- rst asserted mid-job forces IDLE on the next edge, discarding all job state.
- Latency: the first out_valid appears the cycle after the final pass-ending beat is accepted.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: during DRAIN, negative accumulator values output as 0 before saturation; positive values saturate as normal.
- Undefined: signed saturation only, negative values pass through clamped.

Test Plan:
- Config group_count=1, pixel_count=4, TM=16; feed 64 beats with data=ch*4+addr -> 4 drain words, word addr a with channel c equal to c*4+a; done pulses once.
- Config group_count=3; each pass writes 100 to ch0/addr0 (overwrite in pass 0) -> drain ch0/addr0 = 300, proving pass 0 does not add stale data.
- Accumulate 3 × 30000 with FEATURE_WIDTH=16 -> drain value 32767; accumulate 3 × (-30000) -> -32768, or 0 with PSUM_RELU_EN.
- Hold out_ready=0 for 5 cycles mid-drain -> out_data and out_addr stable; no word skipped or duplicated.
- Config with pixel_count=0 -> err_cfg pulse, busy stays 0. Then a legal job with one beat at in_addr=pixel_count -> err_range=1, no write.
- Assert rst during ACCUM after 10 beats -> next cycle busy=0, in_ready=0; a new job completes correctly.
